// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO buffer with registered read data, occupancy flags and sticky errors.
// Optional build macro PARITY_EN adds an even-parity bit per entry and a parity_err output.
module sync_fifo_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_vld,
`ifdef PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

`ifdef PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [MEM_W-1:0]    mem [FIFO_DEPTH];
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic                rd_acc;
    logic                wr_acc;
    logic [MEM_W-1:0]    wr_word;
    logic [MEM_W-1:0]    rd_word;

    // Flags decode the registered count, so they track the post-edge state.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A full FIFO only takes a write when a read frees a slot in the same cycle;
    // an empty FIFO never forwards same-cycle write data.
    assign rd_acc = !flush && rd_en && !empty;
    assign wr_acc = !flush && wr_en && (!full || rd_acc);

`ifdef PARITY_EN
    assign wr_word = {^wdata, wdata};
`else
    assign wr_word = wdata;
`endif
    assign rd_word = mem[rd_ptr[ADDR_WIDTH-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ONE;
            if (rd_acc) rd_ptr <= rd_ptr + ONE;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata     <= '0;
            rdata_vld <= 1'b0;
        end else begin
            rdata_vld <= rd_acc;
            if (rd_acc) rdata <= rd_word[DATA_WIDTH-1:0];
        end
    end

`ifdef PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_err <= 1'b0;
        else        parity_err <= rd_acc && (^rd_word);
    end
`endif

    // A fresh error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (!flush && wr_en && !wr_acc) overflow <= 1'b1;
            else if (clr_err)               overflow <= 1'b0;
            if (!flush && rd_en && !rd_acc) underflow <= 1'b1;
            else if (clr_err)               underflow <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst_n) assert ((wr_ptr - rd_ptr) == count);
    end

endmodule

// File: tb/tb_sync_fifo_buf.sv
// Scoreboard bench for sync_fifo_buf: a queue model predicts acceptance, data order and flags.
// Build with PARITY_EN defined to also exercise the parity_err path.
module tb_sync_fifo_buf;
    localparam int DW = 8;
    localparam int DEPTH = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          rd_en = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] rdata;
    logic          rdata_vld;
    logic          full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          overflow, underflow;
`ifdef PARITY_EN
    logic          parity_err;
`endif

    sync_fifo_buf #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wdata(wdata),
        .rd_en(rd_en), .rdata(rdata), .rdata_vld(rdata_vld),
`ifdef PARITY_EN
        .parity_err(parity_err),
`endif
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Entry = {corrupt_marker, data}; corrupt_marker predicts parity_err.
    logic [DW:0]   mq[$];
    logic [DW-1:0] m_rdata = '0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_flags();
        int n;
        n = mq.size();
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= DEPTH - 1));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 1));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic model_reset();
        mq.delete();
        m_rdata = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, then compare just after the edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                        input logic f = 1'b0, input logic c = 1'b0);
        logic racc, wacc, exp_vld, exp_perr;
        logic [DW:0] ent;
        wr_en = w; wdata = d; rd_en = r; flush = f; clr_err = c;
        @(posedge clk);
        #1;
        exp_vld = 1'b0;
        exp_perr = 1'b0;
        if (f) begin
            mq.delete();
            if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
        end else begin
            racc = r && (mq.size() != 0);
            wacc = w && ((mq.size() < DEPTH) || racc);
            if (racc) begin
                ent = mq.pop_front();
                m_rdata = ent[DW-1:0];
                exp_perr = ent[DW];
                exp_vld = 1'b1;
            end
            if (wacc) mq.push_back({1'b0, d});
            m_ovf = (w && !wacc) ? 1'b1 : (c ? 1'b0 : m_ovf);
            m_unf = (r && !racc) ? 1'b1 : (c ? 1'b0 : m_unf);
        end
        chk("rdata_vld", 32'(rdata_vld), 32'(exp_vld));
        chk("rdata", 32'(rdata), 32'(m_rdata));
`ifdef PARITY_EN
        chk("parity_err", 32'(parity_err), 32'(exp_perr));
`endif
        check_flags();
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #12;
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_rdata_vld", 32'(rdata_vld), 32'h0);
        check_flags();
        #5 rst_n = 1'b1;
        step(0, 8'h00, 0);

        // fill to full, then one rejected write
        for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h11 + i), 0);
        step(1, 8'h99, 0);

        // drain back-to-back, then one rejected read
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        chk("rdata_hold", 32'(rdata), 32'h18);

        // full FIFO with simultaneous read+write: both pointers wrap
        step(0, 8'h00, 0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h21 + i), 0);
        step(1, 8'hA5, 1);
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1);
        chk("wrap_a5", 32'(rdata), 32'hA5);

        // flush with a concurrent write
        for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0);
        step(1, 8'h77, 1, 1'b1);
        step(1, 8'h3C, 0);
        step(0, 8'h00, 1);
        chk("post_flush", 32'(rdata), 32'h3C);

        // new error beats clr_err in the same cycle
        step(0, 8'h00, 1);
        step(0, 8'h00, 1, 1'b0, 1'b1);
        step(0, 8'h00, 0, 1'b0, 1'b1);

        // random traffic
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));

        // reset in the middle of a read
        step(0, 8'h00, 0, 1'b1);
        for (int i = 0; i < 3; i++) step(1, 8'(8'h60 + i), 0);
        step(0, 8'h00, 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_vld", 32'(rdata_vld), 32'h0);
        chk("midrst_rdata", 32'(rdata), 32'h0);
        check_flags();
        rst_n = 1'b1;
        step(1, 8'h5A, 0);
        step(0, 8'h00, 1);

`ifdef PARITY_EN
        // corrupt the parity bit of the entry at the head (pointers at 0 after reset)
        rst_n = 1'b0;
        #3;
        model_reset();
        rst_n = 1'b1;
        step(1, 8'hC3, 0);
        step(1, 8'h81, 0);
        dut.mem[0][DW] = ~dut.mem[0][DW];
        mq[0][DW] = 1'b1;
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
